multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/imm_src_dec.sv | 23 ++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the FSM state encoding (also visible on state_dbg), the opcode
// constants recognised by the decoder and the 2-bit datapath select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format decoder.
// Ports:
//   op      - instruction opcode
//   imm_src - immediate format select (I/S/B/J), I for anything unrecognised
module imm_src_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        unique case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style main controller (Moore FSM, two-process).
// Parameters:
//   MEM_WAIT_EN - 1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: never wait
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   op, zero, mem_ready - opcode, ALU zero flag, memory access done
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite - enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc   - 2-bit datapath selects
//   illegal_op, retire  - unsupported opcode / instruction-complete pulses
//   state_dbg           - current state encoding
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic       retire,
    output logic [3:0] state_dbg
);

    state_t     state_reg;
    state_t     state_next;
    logic       mem_rdy;
    logic       branch;
    logic       pc_update;
    logic       ir_write;
    logic [1:0] imm_src_raw;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    imm_src_dec u_imm_src_dec (
        .op      (op),
        .imm_src (imm_src_raw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        ir_write   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALUOP_ADD;
        branch     = 1'b0;
        pc_update  = 1'b0;
        illegal_op = 1'b0;
        retire     = 1'b0;

        unique case (state_reg)
            FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                // IR load and PC+4 commit only in the cycle the fetch completes
                ir_write  = mem_rdy;
                pc_update = mem_rdy;
                if (mem_rdy) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                unique case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = SRCA_REG;
                ALUSrcB    = SRCB_IMM;
                state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_rdy) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            EXECUTER: begin
                ALUSrcA    = SRCA_REG;
                ALUSrcB    = SRCB_REG;
                ALUOp      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = SRCA_REG;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                ALUSrcA    = SRCA_REG;
                ALUSrcB    = SRCB_REG;
                ALUOp      = ALUOP_SUB;
                branch     = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = ALUWB;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously, but the FETCH enables must not fire
    // while reset is still held, so they are masked here.
    assign PCWrite   = ~reset & ((branch & zero) | pc_update);
    assign IRWrite   = ~reset & ir_write;
    assign ImmSrc    = reset ? IMM_I : imm_src_raw;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = OP_R;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_ready_nw = 1'b0;
    logic       smp = 1'b0;

    logic       pcw0, adr0, mw0, irw0, rw0, ill0, ret0;
    logic [1:0] rs0, sa0, sb0, aop0, imm0;
    logic [3:0] st0;
    logic       pcw1, adr1, mw1, irw1, rw1, ill1, ret1;
    logic [1:0] rs1, sa1, sb1, aop1, imm1;
    logic [3:0] st1;
    logic [16:0] o0, o1;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       nm;
        bit          which;
        logic [3:0]  st;
        logic [16:0] v;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .RegWrite(rw0),
        .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0), .ImmSrc(imm0),
        .illegal_op(ill0), .retire(ret0), .state_dbg(st0)
    );

    multicycle_ctrl #(.MEM_WAIT_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready_nw),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1),
        .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1), .ImmSrc(imm1),
        .illegal_op(ill1), .retire(ret1), .state_dbg(st1)
    );

    assign o0 = {pcw0, adr0, mw0, irw0, rw0, rs0, sa0, sb0, aop0, imm0, ill0, ret0};
    assign o1 = {pcw1, adr1, mw1, irw1, rw1, rs1, sa1, sb1, aop1, imm1, ill1, ret1};

    // Packs hand-written per-cycle output values in the same order as o0/o1.
    function automatic logic [16:0] mk(input bit pcw, input bit adr, input bit mw,
                                       input bit irw, input bit rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] aop,
                                       input logic [1:0] imm, input bit ill, input bit ret);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm, ill, ret};
    endfunction

    // One clock cycle of stimulus plus the expected outputs for that cycle.
    task automatic cyc(input string nm, input bit rst, input logic [6:0] o, input bit z,
                       input bit mr, input bit which, input logic [3:0] st,
                       input logic [16:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        op        = o;
        zero      = z;
        mem_ready = mr;
        e.nm = nm; e.which = which; e.st = st; e.v = v;
        q.push_back(e);
    endtask

    // Monitor: one comparison pair per queued expectation, sampled mid-cycle
    // or on an explicit sample strobe (used when no clock edge is involved).
    initial begin
        exp_t        e;
        logic [3:0]  a_st;
        logic [16:0] a_v;
        forever begin
            @(negedge clk or posedge smp);
            if (q.size() > 0) begin
                e    = q.pop_front();
                a_st = e.which ? st1 : st0;
                a_v  = e.which ? o1 : o0;
                total++;
                if (a_st !== e.st) begin
                    bad++;
                    $display("FAIL %s state: got %0d want %0d", e.nm, a_st, e.st);
                end
                total++;
                if (a_v !== e.v) begin
                    bad++;
                    $display("FAIL %s outputs: got %b want %b", e.nm, a_v, e.v);
                end
                $display("txn %-12s dut%0d state=%0d outs=%b", e.nm, e.which, a_st, a_v);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [16:0] v_rst;
        exp_t        e;
        v_rst = mk(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0);

        // Reset state
        cyc("rst",        1, OP_R, 0, 1, 0, FETCH, v_rst);

        // R-type, no waits
        cyc("r_fetch",    0, OP_R, 0, 1, 0, FETCH,    mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        cyc("r_dec",      0, OP_R, 0, 1, 0, DECODE,   mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
        cyc("r_exe",      0, OP_R, 0, 1, 0, EXECUTER, mk(0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00, 0,0));
        cyc("r_wb",       0, OP_R, 0, 1, 0, ALUWB,    mk(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));

        // lw with two wait cycles in MEMREAD; op scrambled while waiting
        cyc("lw_fetch",   0, OP_LW, 0, 1, 0, FETCH,   mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        cyc("lw_dec",     0, OP_LW, 0, 1, 0, DECODE,  mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
        cyc("lw_adr",     0, OP_LW, 0, 1, 0, MEMADR,  mk(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0));
        cyc("lw_rd0",     0, 7'b1111111, 0, 0, 0, MEMREAD, mk(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        cyc("lw_rd1",     0, 7'b1111111, 0, 0, 0, MEMREAD, mk(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        cyc("lw_rd2",     0, OP_LW, 0, 1, 0, MEMREAD, mk(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        cyc("lw_wb",      0, OP_LW, 0, 1, 0, MEMWB,   mk(0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b00, 0,1));

        // beq taken, with one fetch stall first
        cyc("b1_fstall",  0, OP_BEQ, 0, 0, 0, FETCH,  mk(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
        cyc("b1_fetch",   0, OP_BEQ, 0, 1, 0, FETCH,  mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
        cyc("b1_dec",     0, OP_BEQ, 0, 1, 0, DECODE, mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
        cyc("b1_beq",     0, OP_BEQ, 1, 1, 0, BEQ,    mk(1,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 0,1));
        // beq not taken
        cyc("b0_fetch",   0, OP_BEQ, 0, 1, 0, FETCH,  mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
        cyc("b0_dec",     0, OP_BEQ, 0, 1, 0, DECODE, mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
        cyc("b0_beq",     0, OP_BEQ, 0, 1, 0, BEQ,    mk(0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 0,1));

        // Illegal opcode, then back to FETCH (which starts a jal)
        cyc("ill_fetch",  0, 7'b1111111, 0, 1, 0, FETCH,  mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        cyc("ill_dec",    0, 7'b1111111, 0, 1, 0, DECODE, mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 1,0));
        cyc("j_fetch",    0, OP_JAL, 0, 1, 0, FETCH,  mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b11, 0,0));
        cyc("j_dec",      0, OP_JAL, 0, 1, 0, DECODE, mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b11, 0,0));
        cyc("j_jal",      0, OP_JAL, 0, 1, 0, JAL,    mk(1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b11, 0,0));
        cyc("j_wb",       0, OP_JAL, 0, 1, 0, ALUWB,  mk(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b11, 0,1));

        // sw, reset asserted mid-cycle while waiting in MEMWRITE
        cyc("sw_fetch",   0, OP_SW, 0, 1, 0, FETCH,    mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b01, 0,0));
        cyc("sw_dec",     0, OP_SW, 0, 1, 0, DECODE,   mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b01, 0,0));
        cyc("sw_adr",     0, OP_SW, 0, 1, 0, MEMADR,   mk(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0));
        cyc("sw_wr",      0, OP_SW, 0, 0, 0, MEMWRITE, mk(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,0));
        #6;
        reset = 1'b1;
        #1;
        e.nm = "rst_async"; e.which = 0; e.st = FETCH; e.v = v_rst;
        q.push_back(e);
        smp = 1'b1;
        #1;
        smp = 1'b0;
        cyc("rst_hold",   1, OP_SW, 0, 0, 0, FETCH, v_rst);

        // No-wait instance: sw completes in 4 cycles with mem_ready low
        cyc("nw_fetch",   0, OP_SW, 0, 0, 1, FETCH,    mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b01, 0,0));
        cyc("nw_dec",     0, OP_SW, 0, 0, 1, DECODE,   mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b01, 0,0));
        cyc("nw_adr",     0, OP_SW, 0, 0, 1, MEMADR,   mk(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0));
        cyc("nw_wr",      0, OP_SW, 0, 0, 1, MEMWRITE, mk(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,1));
        cyc("nw_next",    0, OP_SW, 0, 0, 1, FETCH,    mk(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b01, 0,0));

        repeat (2) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
